// File: rtl/rv32_lsu_pkg.sv
// Shared opcodes, funct3 encodings, FSM state type and lane helpers for the MEM-stage load/store unit.
package rv32_lsu_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   // funct3[1:0] is the access size for both loads and stores
   function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lsu_store_lanes(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] wd;
      case (f3[1:0])
         2'b00:   wd = {4{sd[7:0]}};
         2'b01:   wd = {2{sd[15:0]}};
         default: wd = sd;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: selects the addressed lane of the read word and extends it.
module lsu_load_align
   import rv32_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      ld_data = rdata;
      case (funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ld_data = {24'h000000, shifted[7:0]};
         F3_HU:   ld_data = {16'h0000, shifted[15:0]};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: decodes RV32I loads/stores and runs one req/ack transaction per op.
//
//   state | meaning
//   IDLE  | waiting for an aligned memory op; accepting one raises stall
//   BUSY  | dmem_req held until ack or wait-counter timeout
//   DONE  | one-cycle completion slot; ld_valid/bus_err pulse, input ignored
module dmem_lsu
   import rv32_lsu_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] instruction,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        misalign,
   output logic        bus_err
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   lsu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        is_load_q, is_load_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic        ld_valid_q, ld_valid_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic        is_ld, is_st, mem_op, mis;
   logic [31:0] aligned;
   logic        unused_ok;

   assign opcode    = instruction[6:0];
   assign f3        = instruction[14:12];
   assign unused_ok = ^{instruction[31:15], instruction[11:7]};

   lsu_load_align u_align (
      .rdata   (dmem_rdata),
      .offset  (off_q),
      .funct3  (f3_q),
      .ld_data (aligned)
   );

   always_comb begin
      is_ld  = (opcode == OP_LOAD) && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      is_st  = (opcode == OP_STORE) && (f3 inside {F3_B, F3_H, F3_W});
      mem_op = in_valid && (is_ld || is_st);
      mis    = ((f3[1:0] == 2'b01) && addr[0]) ||
               ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cnt_inc    = cnt_q + CW'(1);
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      is_load_d  = is_load_q;
      f3_d       = f3_q;
      off_d      = off_q;
      ld_data_d  = ld_data_q;
      ld_valid_d = 1'b0;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      stall      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               if (mis) begin
                  misalign_d = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_d   = ST_BUSY;
                  cnt_d     = '0;
                  req_d     = 1'b1;
                  we_d      = is_st;
                  addr_d    = {addr[31:2], 2'b00};
                  wdata_d   = lsu_store_lanes(f3, store_data);
                  be_d      = lsu_byte_en(f3, addr[1:0]);
                  is_load_d = is_ld;
                  f3_d      = f3;
                  off_d     = addr[1:0];
               end
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            // ack takes priority over a timeout landing in the same cycle
            if (dmem_ack) begin
               req_d   = 1'b0;
               state_d = ST_DONE;
               if (is_load_q) begin
                  ld_data_d  = aligned;
                  ld_valid_d = 1'b1;
               end
            end else if (cnt_inc == CW'(MAX_WAIT)) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               cnt_d     = cnt_inc;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         is_load_q  <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         ld_data_q  <= '0;
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         is_load_q  <= is_load_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         ld_data_q  <= ld_data_d;
         ld_valid_q <= ld_valid_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;
   assign ld_data    = ld_data_q;
   assign ld_valid   = ld_valid_q;
   assign misalign   = misalign_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: driver pushes expected requests/events, a monitor pops and compares.
module tb_dmem_lsu;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] instruction, addr, store_data;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, ld_data;
   logic [3:0]  dmem_be;
   logic        dmem_ack, ld_valid, misalign, bus_err;

   always #5 clk = ~clk;

   dmem_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
      .addr(addr), .store_data(store_data), .stall(stall), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign), .bus_err(bus_err)
   );

   typedef struct {
      logic [2:0]  kind;   // {ld_valid, bus_err, misalign}
      logic [31:0] data;
   } ev_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        chk_wdata;
      int          len;
   } rq_t;

   ev_t evq[$];
   rq_t rqq[$];
   int total = 0;
   int bad = 0;
   logic [31:0] last_ld;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] be;
      int o;
      be = 4'b0000;
      o = int'(a[1:0]);
      for (int i = 0; i < acc_size(f3); i++) be[o + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w;
      int n;
      n = acc_size(f3);
      w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
      logic [31:0] v, mask;
      int n;
      n = acc_size(f3);
      v = rd >> (8 * int'(a[1:0]));
      if (n < 4) begin
         mask = (32'h1 << (8 * n)) - 32'h1;
         v = v & mask;
         if (!f3[2] && v[8*n - 1]) v = v | ~mask;
      end
      return v;
   endfunction

   function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic st);
      logic [31:0] r;
      r = $urandom;
      r[14:12] = f3;
      r[6:0] = st ? 7'b0100011 : 7'b0000011;
      return r;
   endfunction

   function automatic logic [31:0] non_mem_instr();
      logic [31:0] r;
      int sel;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: r[6:0] = 7'b0110011;
         1: begin
            r[6:0] = 7'b0000011;
            sel = $urandom_range(0, 2);
            r[14:12] = (sel == 0) ? 3'b011 : ((sel == 1) ? 3'b110 : 3'b111);
         end
         2: begin
            r[6:0] = 7'b0100011;
            r[14:12] = 3'($urandom_range(3, 7));
         end
         default: r[6:0] = 7'b1100011;
      endcase
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         instruction = non_mem_instr();
         addr        = $urandom;
         dmem_ack    = 1'($urandom_range(0, 1));
         dmem_rdata  = $urandom;
         @(negedge clk);
         check("idle_stall", 32'(stall), 32'd0);
         step();
      end
      in_valid = 1'b0;
      dmem_ack = 1'b0;
   endtask

   task automatic do_mis(input logic [2:0] f3, input logic st, input logic [31:0] a,
                         input logic [31:0] sd);
      ev_t e;
      in_valid = 1'b1;
      instruction = mk_instr(f3, st);
      addr = a;
      store_data = sd;
      e.kind = 3'b001;
      e.data = '0;
      evq.push_back(e);
      @(negedge clk);
      check("mis_stall", 32'(stall), 32'd0);
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_mem(input logic [2:0] f3, input logic st, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int dly);
      ev_t e;
      rq_t r;
      logic tmo;
      tmo = (dly >= MAX_WAIT);
      r.addr = {a[31:2], 2'b00};
      r.we = st;
      r.be = ref_be(f3, a);
      r.wdata = ref_wdata(f3, sd);
      r.chk_wdata = st;
      r.len = tmo ? MAX_WAIT : dly + 1;
      rqq.push_back(r);
      if (tmo) begin
         e.kind = 3'b010;
         e.data = last_ld;
         evq.push_back(e);
      end else if (!st) begin
         e.kind = 3'b100;
         e.data = ref_load(f3, a, rd);
         last_ld = e.data;
         evq.push_back(e);
      end

      in_valid = 1'b1;
      instruction = mk_instr(f3, st);
      addr = a;
      store_data = sd;
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      @(negedge clk);
      check("accept_stall", 32'(stall), 32'd1);
      step();
      for (int k = 0; k < MAX_WAIT; k++) begin
         dmem_ack = (k == dly);
         dmem_rdata = (k == dly) ? rd : $urandom;
         @(negedge clk);
         check("busy_stall", 32'(stall), 32'd1);
         step();
         if (k == dly) break;
      end
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      @(negedge clk);
      check("done_stall", 32'(stall), 32'd0);
      step();
      in_valid = 1'b0;
      dmem_ack = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] f3, input logic st, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int dly);
      int n;
      n = acc_size(f3);
      if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) do_mis(f3, st, a, sd);
      else do_mem(f3, st, a, sd, rd, dly);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_req"}, 32'(dmem_req), 32'd0);
      check({tag, "_we"}, 32'(dmem_we), 32'd0);
      check({tag, "_addr"}, dmem_addr, 32'd0);
      check({tag, "_wdata"}, dmem_wdata, 32'd0);
      check({tag, "_be"}, 32'(dmem_be), 32'd0);
      check({tag, "_ld_data"}, ld_data, 32'd0);
      check({tag, "_pulses"}, 32'({ld_valid, bus_err, misalign}), 32'd0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic req_prev, have, stable;
      int len;
      rq_t cur;
      logic [31:0] s_addr, s_wdata;
      logic [3:0] s_be;
      logic s_we;
      ev_t e;
      req_prev = 1'b0;
      have = 1'b0;
      stable = 1'b1;
      len = 0;
      forever begin
         @(negedge clk);
         if (ld_valid === 1'b1 || bus_err === 1'b1 || misalign === 1'b1) begin
            if (evq.size() == 0) begin
               check("unexpected_event", 32'({ld_valid, bus_err, misalign}), 32'd0);
            end else begin
               e = evq.pop_front();
               check("event_kind", 32'({ld_valid, bus_err, misalign}), 32'(e.kind));
               if (e.kind != 3'b001) check("ld_data", ld_data, e.data);
            end
         end
         if (dmem_req === 1'b1 && !req_prev) begin
            if (rqq.size() == 0) begin
               check("unexpected_req", 32'd1, 32'd0);
               have = 1'b0;
            end else begin
               cur = rqq.pop_front();
               have = 1'b1;
               check("req_addr", dmem_addr, cur.addr);
               check("req_we", 32'(dmem_we), 32'(cur.we));
               check("req_be", 32'(dmem_be), 32'(cur.be));
               if (cur.chk_wdata) check("req_wdata", dmem_wdata, cur.wdata);
            end
            len = 1;
            stable = 1'b1;
            s_addr = dmem_addr;
            s_wdata = dmem_wdata;
            s_be = dmem_be;
            s_we = dmem_we;
         end else if (dmem_req === 1'b1 && req_prev) begin
            len++;
            if (dmem_addr !== s_addr || dmem_wdata !== s_wdata || dmem_be !== s_be ||
                dmem_we !== s_we) stable = 1'b0;
         end else if (dmem_req !== 1'b1 && req_prev && have) begin
            check("req_len", 32'(len), 32'(cur.len));
            check("req_stable", 32'(stable), 32'd1);
            have = 1'b0;
         end
         req_prev = (dmem_req === 1'b1);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0] f3;
      logic st;
      logic [31:0] a;
      int dly, sel, n;

      rst = 1'b1;
      in_valid = 1'b0;
      instruction = '0;
      addr = '0;
      store_data = '0;
      dmem_rdata = '0;
      dmem_ack = 1'b0;
      last_ld = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      step();

      do_op(3'b010, 1'b1, 32'h1000, 32'h12345678, 32'h0, 0);
      do_op(3'b000, 1'b1, 32'h1003, 32'hAABBCCDD, 32'h0, 0);
      do_op(3'b000, 1'b0, 32'h2002, 32'h0, 32'h00800000, 0);
      do_op(3'b100, 1'b0, 32'h2002, 32'h0, 32'h00800000, 1);
      do_op(3'b101, 1'b0, 32'h2002, 32'h0, 32'hBEEF0000, 2);
      do_op(3'b010, 1'b0, 32'h2002, 32'h0, 32'h0, 0);
      idle(2);
      do_op(3'b010, 1'b0, 32'h2004, 32'h0, 32'hCAFEF00D, 0);
      do_op(3'b010, 1'b0, 32'h4000, 32'h0, 32'h0, MAX_WAIT);
      do_op(3'b010, 1'b0, 32'h4000, 32'h0, 32'h13579BDF, MAX_WAIT - 1);
      do_op(3'b001, 1'b1, 32'h5002, 32'h0000A55A, 32'h0, 1);
      do_op(3'b001, 0, 32'h5001, 32'h0, 32'h0, 0);
      idle(2);

      // reset during the second BUSY cycle, then a late ack
      begin
         rq_t r;
         r.addr = 32'h3000;
         r.we = 1'b0;
         r.be = 4'hF;
         r.wdata = '0;
         r.chk_wdata = 1'b0;
         r.len = 2;
         rqq.push_back(r);
         in_valid = 1'b1;
         instruction = mk_instr(3'b010, 1'b0);
         addr = 32'h3000;
         step();
         step();
         rst = 1'b1;
         in_valid = 1'b0;
         step();
         rst = 1'b0;
         check_outputs_zero("midrst");
         dmem_ack = 1'b1;
         dmem_rdata = $urandom;
         step();
         check("late_ack_req", 32'(dmem_req), 32'd0);
         dmem_ack = 1'b0;
         last_ld = '0;
         idle(3);
      end

      for (int i = 0; i < 300; i++) begin
         st = 1'($urandom_range(0, 1));
         if (st) begin
            f3 = 3'($urandom_range(0, 2));
         end else begin
            sel = $urandom_range(0, 4);
            f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
         end
         n = acc_size(f3);
         a = $urandom;
         if ($urandom_range(0, 9) < 8) a = a & ~(32'(n) - 32'd1);
         dly = ($urandom_range(0, 9) < 2) ? MAX_WAIT : $urandom_range(0, MAX_WAIT - 1);
         do_op(f3, st, a, $urandom, $urandom, dly);
         idle($urandom_range(0, 2));
      end

      idle(4);
      check("evq_drained", 32'(evq.size()), 32'd0);
      check("rqq_drained", 32'(rqq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
